// File: rtl/fir_frame_sequencer_pkg.sv
// Shared types and default sizing for the FIR frame sequencer.
// Every sequencer file imports this package.
package fir_seq_pkg;

  typedef enum logic [1:0] {LOAD, STREAM, FLUSH, DRAIN} seq_state_t;

  localparam int N_TAPS_DEF      = 30;
  localparam int DATA_WL_DEF     = 16;
  localparam int DATA_FRAC_DEF   = 12;
  localparam int OUT_WL_DEF      = 16;
  localparam int FIR_LATENCY_DEF = 1;
  localparam int FRAME_MAX_DEF   = 256;

  // Returns the number of bits needed to hold values 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fir_frame_sequencer_if.sv
// Input sample stream and framed output stream of the sequencer.
// The slave view is used by the sequencer; the master view is used by the source and sink.
interface fir_frame_sequencer_if #(
  parameter int DATA_WL = 16,
  parameter int OUT_WL  = 16
);
  logic [DATA_WL-1:0] s_data;
  logic               s_valid;
  logic               s_last;
  logic               s_ready;
  logic [OUT_WL-1:0]  m_data;
  logic               m_valid;
  logic               m_last;

  modport slave  (input  s_data, s_valid, s_last, output s_ready,
                  output m_data, m_valid, m_last);
  modport master (output s_data, s_valid, s_last, input  s_ready,
                  input  m_data, m_valid, m_last);
endinterface

// File: rtl/fir_seq_frame_ram.sv
// Frame buffer: one write port and one synchronous read port.
// A read of the address being written returns the new data, and a disabled read returns zero.
module fir_seq_frame_ram #(
  parameter int DATA_WL = 16,
  parameter int DEPTH   = 256,
  parameter int AW      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we_i,
  input  logic [AW-1:0]      wr_addr_i,
  input  logic [DATA_WL-1:0] wr_data_i,
  input  logic               rd_en_i,
  input  logic [AW-1:0]      rd_addr_i,
  output logic [DATA_WL-1:0] rd_data_o
);
  logic [DATA_WL-1:0] mem_q [DEPTH];
  logic [DATA_WL-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Write-first bypass covers a one-sample frame, whose sample is written on the same edge it is read.
  always_ff @(posedge clk) begin
    if (rst)                                 rd_data_q <= '0;
    else if (!rd_en_i)                       rd_data_q <= '0;
    else if (we_i && wr_addr_i == rd_addr_i) rd_data_q <= wr_data_i;
    else                                     rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/fir_frame_sequencer.sv
// Buffers one input frame, streams it into the FIR, flushes the FIR with zeros,
// and re-times the FIR output into a framed stream with aligned valid and last.
//
//   state  | meaning
//   LOAD   | accept samples into the frame buffer
//   STREAM | drive buffered samples to the FIR on consecutive cycles
//   FLUSH  | drive N_TAPS-1 zeros to push out the tail
//   DRAIN  | wait out the FIR latency before the next frame
module fir_frame_sequencer
  import fir_seq_pkg::*;
#(
  parameter int DATA_WL     = DATA_WL_DEF,
  parameter int OUT_WL      = OUT_WL_DEF,
  parameter int N_TAPS      = N_TAPS_DEF,
  parameter int FIR_LATENCY = FIR_LATENCY_DEF,
  parameter int FRAME_MAX   = FRAME_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  fir_frame_sequencer_if.slave bus,
  output logic [DATA_WL-1:0]   fir_data_in,
  output logic                 fir_in_valid,
  input  logic [OUT_WL-1:0]    fir_data_out,
  output logic                 busy,
  output logic                 err_overflow
);
  localparam int AW = cnt_w(FRAME_MAX - 1);
  localparam int CW = cnt_w(FRAME_MAX);
  localparam int TW = cnt_w((N_TAPS - 2 > FIR_LATENCY - 1) ? N_TAPS - 2 : FIR_LATENCY - 1);
  localparam logic [CW-1:0] FRAME_MAX_C = CW'(FRAME_MAX);

  seq_state_t       state_q, state_d;
  logic [CW-1:0]    wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]    frame_len_q, frame_len_d;
  logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             err_q, err_d;
  logic             fir_valid_q, fir_valid_d;
  logic             fir_last_q, fir_last_d;
  logic [FIR_LATENCY-1:0] vdly_q, ldly_q;
  logic             ram_we, ram_rd_en;

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    frame_len_d = frame_len_q;
    rd_cnt_d    = rd_cnt_q;
    tmr_d       = tmr_q;
    err_d       = err_q;
    ram_we      = 1'b0;
    ram_rd_en   = 1'b0;
    case (state_q)
      LOAD: begin
        if (bus.s_valid) begin
          if (wr_cnt_q == FRAME_MAX_C) begin
            err_d = 1'b1;
          end else begin
            ram_we   = 1'b1;
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
          // Prefetch sample 0 on the same edge so STREAM starts without a bubble.
          if (bus.s_last) begin
            frame_len_d = (wr_cnt_q == FRAME_MAX_C) ? FRAME_MAX_C : wr_cnt_q + 1'b1;
            rd_cnt_d    = '0;
            ram_rd_en   = 1'b1;
            state_d     = STREAM;
          end
        end
      end
      STREAM: begin
        if (rd_cnt_q == frame_len_q - 1'b1) begin
          state_d = FLUSH;
          tmr_d   = TW'(N_TAPS - 2);
        end else begin
          rd_cnt_d  = rd_cnt_q + 1'b1;
          ram_rd_en = 1'b1;
        end
      end
      FLUSH: begin
        if (tmr_q == '0) begin
          state_d = DRAIN;
          tmr_d   = TW'(FIR_LATENCY - 1);
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      DRAIN: begin
        if (tmr_q == '0) begin
          state_d  = LOAD;
          wr_cnt_d = '0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
    fir_valid_d = (state_d == STREAM) || (state_d == FLUSH);
    fir_last_d  = (state_d == FLUSH) && (tmr_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      wr_cnt_q    <= '0;
      frame_len_q <= '0;
      rd_cnt_q    <= '0;
      tmr_q       <= '0;
      err_q       <= 1'b0;
      fir_valid_q <= 1'b0;
      fir_last_q  <= 1'b0;
      vdly_q      <= '0;
      ldly_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      frame_len_q <= frame_len_d;
      rd_cnt_q    <= rd_cnt_d;
      tmr_q       <= tmr_d;
      err_q       <= err_d;
      fir_valid_q <= fir_valid_d;
      fir_last_q  <= fir_last_d;
      vdly_q[0]   <= fir_valid_q;
      ldly_q[0]   <= fir_last_q;
      for (int i = 1; i < FIR_LATENCY; i++) begin
        vdly_q[i] <= vdly_q[i-1];
        ldly_q[i] <= ldly_q[i-1];
      end
    end
  end

  fir_seq_frame_ram #(
    .DATA_WL (DATA_WL),
    .DEPTH   (FRAME_MAX),
    .AW      (AW)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .we_i      (ram_we),
    .wr_addr_i (wr_cnt_q[AW-1:0]),
    .wr_data_i (bus.s_data),
    .rd_en_i   (ram_rd_en),
    .rd_addr_i (rd_cnt_d[AW-1:0]),
    .rd_data_o (fir_data_in)
  );

  assign bus.s_ready  = (state_q == LOAD);
  assign busy         = (state_q != LOAD);
  assign err_overflow = err_q;
  assign fir_in_valid = fir_valid_q;
  assign bus.m_valid  = vdly_q[FIR_LATENCY-1];
  assign bus.m_last   = ldly_q[FIR_LATENCY-1];
  assign bus.m_data   = bus.m_valid ? fir_data_out : '0;
endmodule

// File: tb/tb_fir_frame_sequencer.sv
// Testbench for fir_frame_sequencer, with a behavioural 30-tap FIR (latency 1) on the FIR ports.
// A direct-convolution scoreboard checks every output beat.
module tb_fir_frame_sequencer;
  localparam int N_TAPS    = 30;
  localparam int FRAME_MAX = 256;
  localparam int H_COEF [30] = '{29, -41, 60, -88, 120, -160, 210, -270, 345, -440,
                                 560, -720, 950, -1320, 1692, 1692, -1320, 950, -720, 560,
                                 -440, 345, -270, 210, -160, 120, -88, 60, -41, 29};

  typedef struct {
    string      name;
    int         len;
    logic [15:0] first;
    bit         rnd;
    bit         gap;
    bit         exp_err;
    int         exp_beats;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } exp_t;

  logic        clk, rst;
  logic [15:0] fir_data_in, fir_data_out;
  logic        fir_in_valid, busy, err_overflow;

  fir_frame_sequencer_if #(.DATA_WL(16), .OUT_WL(16)) bus ();

  fir_frame_sequencer #(
    .DATA_WL(16), .OUT_WL(16), .N_TAPS(N_TAPS), .FIR_LATENCY(1), .FRAME_MAX(FRAME_MAX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .fir_data_in  (fir_data_in),
    .fir_in_valid (fir_in_valid),
    .fir_data_out (fir_data_out),
    .busy         (busy),
    .err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIR: consumes fir_data_in every cycle, one cycle of latency.
  logic signed [15:0] fir_hist [N_TAPS];
  always @(posedge clk) begin : fir_model
    longint acc;
    if (rst) begin
      for (int i = 0; i < N_TAPS; i++) fir_hist[i] = '0;
      fir_data_out <= '0;
    end else begin
      for (int i = N_TAPS - 1; i > 0; i--) fir_hist[i] = fir_hist[i-1];
      fir_hist[0] = fir_data_in;
      acc = 0;
      for (int k = 0; k < N_TAPS; k++) acc += longint'(fir_hist[k]) * H_COEF[k];
      fir_data_out <= 16'(acc >>> 12);
    end
  end

  int checks = 0;
  int errors = 0;
  exp_t exp_q [$];
  logic signed [15:0] xbuf [512];
  int beat_cnt, fiv_cnt, fiv_runs;
  bit last_seen, fiv_prev;
  vec_t vecs [6];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (fir_in_valid) begin
        fiv_cnt++;
        if (!fiv_prev) fiv_runs++;
      end
      fiv_prev = fir_in_valid;
      if (bus.m_valid) begin
        beat_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL m_beat unexpected beat data=%h last=%b", bus.m_data, bus.m_last);
        end else begin
          e = exp_q.pop_front();
          if (bus.m_data !== e.data || bus.m_last !== e.last) begin
            errors++;
            $display("FAIL m_beat %0d actual=%h/%b expected=%h/%b",
                     beat_cnt - 1, bus.m_data, bus.m_last, e.data, e.last);
          end
        end
        if (bus.m_last) last_seen = 1'b1;
      end else if (bus.m_last) begin
        checks++;
        errors++;
        $display("FAIL m_last_without_valid actual=1 expected=0");
      end
    end
  end

  task automatic push_expected(input int len);
    int le;
    longint acc;
    exp_t e;
    le = (len > FRAME_MAX) ? FRAME_MAX : len;
    for (int n = 0; n < le + N_TAPS - 1; n++) begin
      acc = 0;
      for (int k = 0; k < N_TAPS; k++)
        if (n - k >= 0 && n - k < le) acc += longint'(xbuf[n-k]) * H_COEF[k];
      e.data = 16'(acc >>> 12);
      e.last = (n == le + N_TAPS - 2);
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_counts();
    beat_cnt = 0; fiv_cnt = 0; fiv_runs = 0; last_seen = 1'b0;
  endtask

  task automatic send_frame(input int first, input int len, input bit gap);
    for (int i = first; i < len; i++) begin
      if (gap && i > first) begin
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.s_data  = xbuf[i];
      bus.s_valid = 1'b1;
      bus.s_last  = (i == len - 1);
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (last_seen && !busy) begin ok = 1'b1; break; end
    end
    check({name, "_done"}, ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v);
    clear_counts();
    for (int i = 0; i < v.len; i++)
      xbuf[i] = v.rnd ? 16'($urandom_range(0, 8191) - 4096) : ((i == 0) ? v.first : 16'h0000);
    push_expected(v.len);
    send_frame(0, v.len, v.gap);
    wait_done(v.name);
    check({v.name, "_beats"}, beat_cnt, v.exp_beats);
    check({v.name, "_fir_valid_cycles"}, fiv_cnt, v.exp_beats);
    check({v.name, "_fir_valid_runs"}, fiv_runs, 1);
    check({v.name, "_err_overflow"}, err_overflow, v.exp_err);
    check({v.name, "_queue_left"}, exp_q.size(), 0);
  endtask

  initial begin
    bit found;
    int viol;
    vecs[0] = '{"impulse",  1,   16'h1000, 1'b0, 1'b0, 1'b0, 30};
    vecs[1] = '{"b2b_a",    4,   16'h1000, 1'b0, 1'b0, 1'b0, 33};
    vecs[2] = '{"b2b_b",    4,   16'h0800, 1'b0, 1'b0, 1'b0, 33};
    vecs[3] = '{"bursty",   8,   16'h0000, 1'b1, 1'b1, 1'b0, 37};
    vecs[4] = '{"full",     256, 16'h0000, 1'b1, 1'b0, 1'b0, 285};
    vecs[5] = '{"overflow", 259, 16'h0000, 1'b1, 1'b0, 1'b1, 285};

    rst = 1'b1;
    bus.s_data = '0; bus.s_valid = 1'b0; bus.s_last = 1'b0;
    clear_counts();
    fiv_prev = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", bus.s_ready, 1);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_last", bus.m_last, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err_overflow", err_overflow, 0);
    check("rst_fir_in_valid", fir_in_valid, 0);
    check("rst_fir_data_in", fir_data_in, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) run_vec(vecs[v]);

    // Reset during flush cycle 10 of a 4-sample frame.
    clear_counts();
    xbuf[0] = 16'h1000; xbuf[1] = 16'h0800; xbuf[2] = 16'h0400; xbuf[3] = 16'h0200;
    push_expected(4);
    send_frame(0, 4, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (fiv_cnt == 4 + 11) begin found = 1'b1; break; end
    end
    check("flush10_reached", found, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    clear_counts();
    repeat (40) @(posedge clk);
    #1;
    check("post_rst_m_valid_beats", beat_cnt, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_err_overflow", err_overflow, 0);
    check("post_rst_s_ready", bus.s_ready, 1);
    run_vec(vecs[0]);

    // Source keeps s_valid high while the sequencer is busy.
    clear_counts();
    xbuf[0] = 16'h0400; xbuf[1] = 16'h0100; xbuf[2] = 16'hFE00; xbuf[3] = 16'h0300;
    push_expected(4);
    send_frame(0, 4, 1'b0);
    bus.s_valid = 1'b1; bus.s_data = 16'h0C00; bus.s_last = 1'b0;
    viol = 0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (!busy) begin found = 1'b1; break; end
      if (bus.s_ready) viol++;
    end
    check("bp_idle_reached", found, 1);
    check("bp_ready_while_busy", viol, 0);
    check("bp_ready_after_drain", bus.s_ready, 1);
    check("bp_frame1_beats", beat_cnt, 33);
    check("bp_frame1_queue_left", exp_q.size(), 0);
    clear_counts();
    xbuf[0] = 16'h0C00; xbuf[1] = 16'h0200; xbuf[2] = 16'h0000; xbuf[3] = 16'h0100;
    push_expected(4);
    @(posedge clk); #1;
    send_frame(1, 4, 1'b0);
    wait_done("bp_frame2");
    check("bp_frame2_beats", beat_cnt, 33);
    check("bp_frame2_queue_left", exp_q.size(), 0);
    check("bp_err_overflow", err_overflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
